rook: RTL and testbench

- Memory-mapped hardware accelerator that generates all pseudo-legal moves for one rook on an 8x8 chess board.
- Software writes a board pointer, an output pointer and a rook piece ID through an Avalon-MM slave, then starts the block.
- Through an Avalon-MM master, the block reads the 64-square board, then writes one complete 64-square successor board per legal rook move.
- A blocking slave read returns the number of moves generated.

---
 rtl/chess_pkg.sv | 36 +++
 rtl/rook_board_buf.sv | 25 ++
 rtl/rook.sv | 221 ++++++++++++++++++++++
 tb/tb_rook.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared chess types and constants: piece codes, square index, FSM states,
// scan directions and the slave register map.
package chess_pkg;

  typedef logic [5:0]        sq_t;
  typedef logic signed [7:0] piece_t;

  localparam piece_t EMPTY   = 8'sd0;
  localparam piece_t W_PAWN0 = 8'sd1;
  localparam piece_t W_ROOK0 = 8'sd9;
  localparam piece_t W_ROOK1 = 8'sd10;
  localparam piece_t W_KING  = 8'sd48;
  localparam piece_t B_PAWN0 = -8'sd1;
  localparam piece_t B_ROOK0 = -8'sd9;
  localparam piece_t B_ROOK1 = -8'sd10;
  localparam piece_t B_KING  = -8'sd48;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_FIND, ST_SCAN, ST_EMIT, ST_DONE
  } state_t;

  // DIR_END marks all four rays exhausted
  typedef enum logic [2:0] {
    DIR_N, DIR_S, DIR_E, DIR_W, DIR_END
  } dir_t;

  localparam logic [3:0] REG_CTRL  = 4'd0;
  localparam logic [3:0] REG_SRC   = 4'd1;
  localparam logic [3:0] REG_PIECE = 4'd2;
  localparam logic [3:0] REG_DST   = 4'd3;

  function automatic logic [31:0] sext8(input piece_t p);
    return {{24{p[7]}}, p};
  endfunction

endpackage

// File: rtl/rook_board_buf.sv
// 64-square board copy: one write port filled during LOAD, two asynchronous
// read ports (ray lookup and successor-board streaming).
module rook_board_buf
  import chess_pkg::*;
(
  input  logic   clk,
  input  logic   we,
  input  sq_t    waddr,
  input  piece_t wdata,
  input  sq_t    raddr_a,
  output piece_t rdata_a,
  input  sq_t    raddr_b,
  output piece_t rdata_b
);

  piece_t mem [64];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/rook.sv
// Rook move generator: loads a board over Avalon-MM, writes one successor board
// per pseudo-legal move. ROOK_KING_CAPTURE_BLOCK_EN makes an enemy king a blocker.
module rook
  import chess_pkg::*;
#(
  parameter int MAX_MOVES = 14
)(
  input  logic        clk,
  input  logic        rst_n,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  localparam int CNT_W = $clog2(MAX_MOVES + 1);

  state_t           state, state_nxt;
  logic [31:0]      src_base, dst_base, piece_word;
  piece_t           piece;
  logic [CNT_W-1:0] count;
  sq_t              ld_idx, find_idx, src_sq, cur_sq, dst_sq, em_idx, nxt_sq;
  dir_t             dir;
  logic             rd_wait, stop_after;
  logic             busy, start, cfg_we, rd_done, find_hit;
  logic             at_edge, sq_empty, sq_opp, sq_capt, scan_fin, scan_emit;
  sq_t              raddr_a;
  piece_t           sq_val, em_board, em_val;
  logic             unused_bits;

  assign piece       = piece_word[7:0];
  assign unused_bits = ^{piece_word[31:8], master_readdata[31:8]};

  // DONE counts as not busy so a stalled count read completes there
  assign busy    = (state == ST_LOAD) || (state == ST_FIND) ||
                   (state == ST_SCAN) || (state == ST_EMIT);
  assign cfg_we  = slave_write && !busy;
  assign start   = cfg_we && (slave_address == REG_CTRL);
  assign rd_done = rd_wait && master_readdatavalid;

  rook_board_buf u_buf (
    .clk     (clk),
    .we      ((state == ST_LOAD) && rd_done),
    .waddr   (ld_idx),
    .wdata   (master_readdata[7:0]),
    .raddr_a (raddr_a),
    .rdata_a (sq_val),
    .raddr_b (em_idx),
    .rdata_b (em_board)
  );

  assign raddr_a  = (state == ST_FIND) ? find_idx : nxt_sq;
  assign find_hit = (state == ST_FIND) && (sq_val == piece);

  // Next square along the current ray; rank/file limits stop file wrap-around
  always_comb begin
    at_edge = 1'b1;
    nxt_sq  = cur_sq;
    unique case (dir)
      DIR_N:   begin at_edge = (cur_sq[5:3] == 3'd7); nxt_sq = cur_sq + 6'd8; end
      DIR_S:   begin at_edge = (cur_sq[5:3] == 3'd0); nxt_sq = cur_sq - 6'd8; end
      DIR_E:   begin at_edge = (cur_sq[2:0] == 3'd7); nxt_sq = cur_sq + 6'd1; end
      DIR_W:   begin at_edge = (cur_sq[2:0] == 3'd0); nxt_sq = cur_sq - 6'd1; end
      default: ;
    endcase
  end

  assign sq_empty = (sq_val == EMPTY);
  assign sq_opp   = !sq_empty && (sq_val[7] != piece[7]);
`ifdef ROOK_KING_CAPTURE_BLOCK_EN
  assign sq_capt  = sq_opp && (sq_val != W_KING) && (sq_val != B_KING);
`else
  assign sq_capt  = sq_opp;
`endif
  assign scan_fin  = (dir == DIR_END) || (int'(count) >= MAX_MOVES);
  assign scan_emit = !scan_fin && !at_edge && (sq_empty || sq_capt);

  assign em_val = (em_idx == src_sq) ? EMPTY :
                  (em_idx == dst_sq) ? piece : em_board;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: if (rd_done && ld_idx == 6'd63) state_nxt = ST_FIND;
      ST_FIND: begin
        if (find_hit)                state_nxt = ST_SCAN;
        else if (find_idx == 6'd63)  state_nxt = ST_DONE;
      end
      ST_SCAN: begin
        if (scan_fin)       state_nxt = ST_DONE;
        else if (scan_emit) state_nxt = ST_EMIT;
      end
      ST_EMIT: if (!master_waitrequest && em_idx == 6'd63) state_nxt = ST_SCAN;
      ST_DONE: state_nxt = start ? ST_LOAD : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    master_read      = 1'b0;
    master_write     = 1'b0;
    master_address   = '0;
    master_writedata = '0;
    unique case (state)
      ST_LOAD: if (!rd_wait) begin
        master_read    = 1'b1;
        master_address = src_base + 32'(ld_idx);
      end
      ST_EMIT: begin
        master_write     = 1'b1;
        master_address   = dst_base + (32'(count) << 6) + 32'(em_idx);
        master_writedata = sext8(em_val);
      end
      default: ;
    endcase
    slave_waitrequest = busy && (slave_write || (slave_read && slave_address == REG_CTRL));
  end

  always_comb begin
    slave_readdata = '0;
    if (slave_read) begin
      unique case (slave_address)
        REG_CTRL:  slave_readdata = 32'(count);
        REG_SRC:   slave_readdata = src_base;
        REG_PIECE: slave_readdata = piece_word;
        REG_DST:   slave_readdata = dst_base;
        default:   slave_readdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_base   <= '0;
      dst_base   <= '0;
      piece_word <= '0;
      count      <= '0;
      ld_idx     <= '0;
      find_idx   <= '0;
      src_sq     <= '0;
      cur_sq     <= '0;
      dst_sq     <= '0;
      em_idx     <= '0;
      dir        <= DIR_N;
      rd_wait    <= 1'b0;
      stop_after <= 1'b0;
    end else begin
      if (cfg_we) begin
        unique case (slave_address)
          REG_SRC:   src_base   <= slave_writedata;
          REG_PIECE: piece_word <= slave_writedata;
          REG_DST:   dst_base   <= slave_writedata;
          default:   ;
        endcase
      end
      unique case (state)
        ST_IDLE, ST_DONE: if (start) begin
          count    <= '0;
          ld_idx   <= '0;
          find_idx <= '0;
          rd_wait  <= 1'b0;
        end
        ST_LOAD: begin
          if (master_read && !master_waitrequest) rd_wait <= 1'b1;
          if (rd_done) begin
            rd_wait <= 1'b0;
            ld_idx  <= ld_idx + 6'd1;
          end
        end
        ST_FIND: begin
          find_idx <= find_idx + 6'd1;
          if (find_hit) begin
            src_sq <= find_idx;
            cur_sq <= find_idx;
            dir    <= DIR_N;
          end
        end
        ST_SCAN: if (!scan_fin) begin
          if (scan_emit) begin
            dst_sq     <= nxt_sq;
            stop_after <= !sq_empty;
            em_idx     <= '0;
          end else begin
            dir    <= dir_t'(dir + 3'd1);
            cur_sq <= src_sq;
          end
        end
        // a capture ends its ray; a quiet move continues from the new square
        ST_EMIT: if (!master_waitrequest) begin
          em_idx <= em_idx + 6'd1;
          if (em_idx == 6'd63) begin
            count <= count + 1'b1;
            if (stop_after) begin
              dir    <= dir_t'(dir + 3'd1);
              cur_sq <= src_sq;
            end else begin
              cur_sq <= dst_sq;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rook.sv
// Directed bench for rook: table of boards with hand-computed move lists, plus
// wait-state, busy-stall and mid-operation reset sequences.
module tb_rook;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slave_waitrequest;
  logic [3:0]  slave_address = '0;
  logic        slave_read = 1'b0;
  logic [31:0] slave_readdata;
  logic        slave_write = 1'b0;
  logic [31:0] slave_writedata = '0;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;

  rook dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic        rnd_mode = 1'b0;
  int          rd_lat = 1;
  logic        mem_clr = 1'b0;
  int          cur_src = 0, cur_dst = 0;
  logic [7:0]  rmem [64];
  logic [7:0]  wmem [1024];
  int          stall, pend, rd_count, wr_count, hi_off, both_cnt, ext_bad, addr_bad;
  logic [31:0] rdat_q;
  logic        rdv_q;
  int          roff, woff;

  assign master_waitrequest   = (stall != 0);
  assign master_readdata      = rdat_q;
  assign master_readdatavalid = rdv_q;
  assign roff = int'(master_address) - cur_src;
  assign woff = int'(master_address) - cur_dst;

  always @(posedge clk) begin
    if (mem_clr) begin
      stall <= 0; pend <= 0; rdv_q <= 1'b0; rdat_q <= '0;
      rd_count <= 0; wr_count <= 0; hi_off <= -1;
      both_cnt <= 0; ext_bad <= 0; addr_bad <= 0;
      for (int i = 0; i < 1024; i++) wmem[i] <= 8'hEE;
    end else begin
      rdv_q <= 1'b0;
      if (pend > 0) begin
        pend <= pend - 1;
        if (pend == 1) rdv_q <= 1'b1;
      end
      if (stall > 0) stall <= stall - 1;
      else if ((master_read || master_write) && rnd_mode) stall <= int'($urandom_range(3, 0));
      if (master_read && master_write) both_cnt <= both_cnt + 1;
      if (master_read && stall == 0) begin
        rd_count <= rd_count + 1;
        pend     <= rd_lat;
        if (roff < 0 || roff > 63) begin
          addr_bad <= addr_bad + 1;
          rdat_q   <= '0;
        end else rdat_q <= {24'h5a5a5a, rmem[roff[5:0]]};
      end
      if (master_write && stall == 0) begin
        wr_count <= wr_count + 1;
        if (master_writedata[31:8] != {24{master_writedata[7]}}) ext_bad <= ext_bad + 1;
        if (woff < 0 || woff > 1023) addr_bad <= addr_bad + 1;
        else begin
          wmem[woff[9:0]] <= master_writedata[7:0];
          if (woff > hi_off) hi_off <= woff;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic mem_pulse();
    @(negedge clk); mem_clr = 1'b1;
    @(negedge clk); mem_clr = 1'b0;
  endtask

  task automatic slave_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    #1;
    for (int i = 0; i < 20000 && slave_waitrequest; i++) @(negedge clk);
    if (slave_waitrequest) chk("slave_wr_timeout", 1, 0);
    @(posedge clk); #1;
    slave_write = 1'b0;
  endtask

  task automatic slave_rd(input logic [3:0] a, output logic [31:0] d, output int waited);
    @(negedge clk);
    slave_address = a; slave_read = 1'b1;
    #1;
    waited = 0;
    for (int i = 0; i < 20000 && slave_waitrequest; i++) begin
      @(negedge clk);
      waited++;
    end
    if (slave_waitrequest) chk("slave_rd_timeout", 1, 0);
    d = slave_readdata;
    @(posedge clk); #1;
    slave_read = 1'b0;
  endtask

  typedef struct {
    int rook_sq;
    int piece;
    int src;
    int dst;
    int oth_sq [6];
    int oth_pc [6];
    int exp_cnt;
    int exp_dst [14];
  } vec_t;

  vec_t vecs [7];

  task automatic load_board(input vec_t v);
    logic [31:0] pw;
    for (int s = 0; s < 64; s++) rmem[s] = 8'h00;
    pw = v.piece;
    if (v.rook_sq >= 0) rmem[v.rook_sq] = pw[7:0];
    for (int i = 0; i < 6; i++) begin
      pw = v.oth_pc[i];
      if (v.oth_sq[i] >= 0) rmem[v.oth_sq[i]] = pw[7:0];
    end
  endtask

  task automatic start_vec(input vec_t v);
    load_board(v);
    cur_src = v.src;
    cur_dst = v.dst;
    mem_pulse();
    slave_wr(4'd1, v.src);
    slave_wr(4'd2, v.piece);
    slave_wr(4'd3, v.dst);
    slave_wr(4'd0, 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] cnt, pw;
    int          waited, bad;
    logic [7:0]  eb [64];
    start_vec(v);
    slave_rd(4'd0, cnt, waited);
    chk({tag, "_count"}, int'(cnt), v.exp_cnt);
    chk({tag, "_reads"}, rd_count, 64);
    chk({tag, "_writes"}, wr_count, 64 * v.exp_cnt);
    chk({tag, "_hi_addr"}, hi_off, 64 * v.exp_cnt - 1);
    chk({tag, "_rd_wr_overlap"}, both_cnt, 0);
    chk({tag, "_sext_bad"}, ext_bad, 0);
    chk({tag, "_addr_bad"}, addr_bad, 0);
    pw = v.piece;
    for (int k = 0; k < v.exp_cnt && k < 14; k++) begin
      for (int s = 0; s < 64; s++) eb[s] = rmem[s];
      eb[v.rook_sq]     = 8'h00;
      eb[v.exp_dst[k]]  = pw[7:0];
      bad = 0;
      for (int s = 0; s < 64; s++)
        if (wmem[k * 64 + s] != eb[s]) bad++;
      chk($sformatf("%s_blk%0d_dst%0d_badsq", tag, k, v.exp_dst[k]), bad, 0);
    end
    slave_rd(4'd0, cnt, waited);
    chk({tag, "_idle_rd_wait"}, waited, 0);
    chk({tag, "_idle_count"}, int'(cnt), v.exp_cnt);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          w;

    vecs[0] = '{27, 9, 100, 5000, '{-1, -1, -1, -1, -1, -1}, '{0, 0, 0, 0, 0, 0}, 14,
                '{35, 43, 51, 59, 19, 11, 3, 28, 29, 30, 31, 26, 25, 24}};
    vecs[1] = '{27, 9, 0, 0, '{59, 11, 25, 4, 60, 0}, '{1, -1, -10, 48, -48, -9}, 11,
                '{35, 43, 51, 19, 11, 28, 29, 30, 31, 26, 25, 0, 0, 0}};
    vecs[2] = '{0, 9, 0, 0, '{1, 8, -1, -1, -1, -1}, '{2, 3, 0, 0, 0, 0}, 0,
                '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[3] = '{-1, 9, 64, 0, '{5, -1, -1, -1, -1, -1}, '{10, 0, 0, 0, 0, 0}, 0,
                '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
`ifdef ROOK_KING_CAPTURE_BLOCK_EN
    vecs[4] = '{63, -9, 300, 2000, '{47, 61, -1, -1, -1, -1}, '{48, 1, 0, 0, 0, 0}, 3,
                '{55, 62, 61, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
`else
    vecs[4] = '{63, -9, 300, 2000, '{47, 61, -1, -1, -1, -1}, '{48, 1, 0, 0, 0, 0}, 4,
                '{55, 47, 62, 61, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
`endif
    vecs[5] = '{7, 9, 0, 64, '{8, -1, -1, -1, -1, -1}, '{-1, 0, 0, 0, 0, 0}, 14,
                '{15, 23, 31, 39, 47, 55, 63, 6, 5, 4, 3, 2, 1, 0}};
    vecs[6] = '{56, 12, 0, 0, '{55, -1, -1, -1, -1, -1}, '{-1, 0, 0, 0, 0, 0}, 14,
                '{48, 40, 32, 24, 16, 8, 0, 57, 58, 59, 60, 61, 62, 63}};

    // reset state
    mem_pulse();
    repeat (2) @(negedge clk);
    chk("rst_master_read", int'(master_read), 0);
    chk("rst_master_write", int'(master_write), 0);
    chk("rst_master_addr", int'(master_address), 0);
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      slave_rd(4'(a), rd, w);
      chk($sformatf("rst_reg%0d", a), int'(rd), 0);
    end

    // register readback and unmapped address
    slave_wr(4'd1, 32'hDEADBEEF);
    slave_wr(4'd2, 32'h000000F7);
    slave_wr(4'd3, 32'h12345678);
    slave_wr(4'd7, 32'h5);
    slave_rd(4'd1, rd, w); chk("reg_src_rb", int'(rd), int'(32'hDEADBEEF));
    slave_rd(4'd2, rd, w); chk("reg_piece_rb", int'(rd), int'(32'h000000F7));
    slave_rd(4'd3, rd, w); chk("reg_dst_rb", int'(rd), int'(32'h12345678));
    slave_rd(4'd7, rd, w); chk("reg_unmapped", int'(rd), 0);
    chk("reg_rd_nowait", w, 0);

    // table-driven runs
    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // memory stalls and late read data must not change the result
    rnd_mode = 1'b1; rd_lat = 3;
    run_vec(vecs[1], "rnd_v1");
    run_vec(vecs[0], "rnd_v0");
    rnd_mode = 1'b0; rd_lat = 1;

    // busy stalls, then reset in the middle of emitting
    start_vec(vecs[0]);
    @(negedge clk);
    slave_address = 4'd1; slave_write = 1'b1; #1;
    chk("busy_wr_stall", int'(slave_waitrequest), 1);
    slave_write = 1'b0; slave_read = 1'b1; slave_address = 4'd0; #1;
    chk("busy_rd0_stall", int'(slave_waitrequest), 1);
    slave_address = 4'd3; #1;
    chk("busy_rd3_nostall", int'(slave_waitrequest), 0);
    slave_read = 1'b0;
    for (int i = 0; i < 5000 && wr_count < 100; i++) @(negedge clk);
    chk("rst_reach_emit", int'(wr_count >= 100), 1);
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk("midrst_master_write", int'(master_write), 0);
    chk("midrst_master_read", int'(master_read), 0);
    chk("midrst_master_addr", int'(master_address), 0);
    chk("midrst_wdata", int'(master_writedata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    slave_rd(4'd0, rd, w); chk("midrst_count", int'(rd), 0);
    chk("midrst_count_nowait", w, 0);
    slave_rd(4'd1, rd, w); chk("midrst_src", int'(rd), 0);
    run_vec(vecs[0], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
